// File: rtl/button_event_scheduler_if.sv
// ============================================================================
// Module      : button_event_scheduler_if
// Description : Button inputs and indicator/status outputs of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_event_scheduler_if;
  logic [3:0] btn;
  logic [3:0] active_out;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic       overrun;

  modport master (
    output btn,
    input  active_out,
    input  grant_id,
    input  busy,
    input  pending,
    input  overrun
  );

  modport slave (
    input  btn,
    output active_out,
    output grant_id,
    output busy,
    output pending,
    output overrun
  );
endinterface

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// ============================================================================
// Module      : button_event_scheduler
// Description : Four button edges latched as events, served round-robin by one
//               shared hold/gap timer driving a one-hot indicator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_scheduler #(
  parameter int HOLD_CYCLES = 125000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int CNT_W       = 27
) (
  input  logic                      clk,
  input  logic                      reset,
  button_event_scheduler_if.slave   evt_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       s1_q;
  logic [3:0]       s2_q;
  logic [3:0]       pending_q;
  logic [3:0]       pending_d;
  logic             overrun_q;
  logic             overrun_d;
  logic [1:0]       ptr_q;
  logic [3:0]       active_q;
  logic [1:0]       grant_id_q;
  logic             busy_q;

  logic [3:0]       edge_w;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [3:0]       grant_w;

  assign edge_w = s1_q & ~s2_q;

  // Round-robin search starting at ptr; 2-bit add wraps mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && pending_q[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    grant_w   = (state_q == IDLE && win_found) ? (4'b0001 << win_idx) : 4'b0000;
    // A fresh edge wins over the grant clear so a coincident event is re-served.
    pending_d = edge_w | (pending_q & ~grant_w);
    overrun_d = |(edge_w & pending_q & ~grant_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
      ptr_q      <= '0;
      active_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      s1_q      <= evt_bus.btn;
      s2_q      <= s1_q;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_id_q <= win_idx;
            active_q   <= 4'b0001 << win_idx;
            ptr_q      <= win_idx + 2'd1;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == c_HOLD_LAST) begin
            active_q <= '0;
            cnt_q    <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == c_GAP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_bus.active_out = active_q;
  assign evt_bus.grant_id   = grant_id_q;
  assign evt_bus.busy       = busy_q;
  assign evt_bus.pending    = pending_q;
  assign evt_bus.overrun    = overrun_q;

endmodule

`default_nettype wire
